// File: rtl/bip_fetch_decode.sv
// Fetch/decode unit for the 16-bit accumulator CPU: drives the program counter and
// registers datapath control strobes. Optional macro BIP_ILLEGAL_HALT_EN halts on opcodes 01000-11111.
module bip_fetch_decode #(
  parameter int unsigned addr_bus  = 11,
  parameter int unsigned data_size = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic [data_size-1:0] Prog_Data,
  output logic [addr_bus-1:0]  Prog_Addr,
  output logic [addr_bus-1:0]  Operand,
  output logic [1:0]           Sel_A,
  output logic                 Sel_B,
  output logic                 Op,
  output logic                 Wr_Acc,
  output logic                 Wr_Ram,
  output logic                 Halted
);

  localparam int unsigned OPC_W = 5;

  localparam logic [OPC_W-1:0] OPC_HLT  = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_STO  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00111;

  localparam logic [1:0] SEL_A_RAM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t              r_state, w_state_nxt;
  logic [addr_bus-1:0] r_pc, w_pc_nxt;
  logic [addr_bus-1:0] r_operand, w_operand_nxt;
  logic [1:0]          r_sel_a, w_sel_a_nxt;
  logic                r_sel_b, w_sel_b_nxt;
  logic                r_op, w_op_nxt;
  logic                r_wr_acc, w_wr_acc_nxt;
  logic                r_wr_ram, w_wr_ram_nxt;
  logic                r_halted, w_halted_nxt;
  logic [OPC_W-1:0]    w_opcode;

  assign w_opcode = Prog_Data[data_size-1 -: OPC_W];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_RUN;
      r_pc      <= '0;
      r_operand <= '0;
      r_sel_a   <= SEL_A_RAM;
      r_sel_b   <= 1'b0;
      r_op      <= 1'b0;
      r_wr_acc  <= 1'b0;
      r_wr_ram  <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_operand <= w_operand_nxt;
      r_sel_a   <= w_sel_a_nxt;
      r_sel_b   <= w_sel_b_nxt;
      r_op      <= w_op_nxt;
      r_wr_acc  <= w_wr_acc_nxt;
      r_wr_ram  <= w_wr_ram_nxt;
      r_halted  <= w_halted_nxt;
    end
  end

  // Write strobes default low so a stall or halt never repeats a write.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_operand_nxt = r_operand;
    w_sel_a_nxt   = r_sel_a;
    w_sel_b_nxt   = r_sel_b;
    w_op_nxt      = r_op;
    w_wr_acc_nxt  = 1'b0;
    w_wr_ram_nxt  = 1'b0;
    w_halted_nxt  = r_halted;

    case (r_state)
      S_RUN: begin
        if (Enable) begin
          w_operand_nxt = Prog_Data[addr_bus-1:0];
          w_sel_a_nxt   = SEL_A_RAM;
          w_sel_b_nxt   = 1'b0;
          w_op_nxt      = 1'b0;
          w_pc_nxt      = r_pc + addr_bus'(1);
          case (w_opcode)
            OPC_HLT: begin
              w_state_nxt  = S_HALT;
              w_halted_nxt = 1'b1;
              w_pc_nxt     = r_pc;
            end
            OPC_STO: w_wr_ram_nxt = 1'b1;
            OPC_LD:  w_wr_acc_nxt = 1'b1;
            OPC_LDI: begin
              w_sel_a_nxt  = SEL_A_IMM;
              w_wr_acc_nxt = 1'b1;
            end
            OPC_ADD, OPC_ADDI, OPC_SUB, OPC_SUBI: begin
              w_sel_a_nxt  = SEL_A_ALU;
              w_sel_b_nxt  = w_opcode[0];
              w_op_nxt     = w_opcode[1];
              w_wr_acc_nxt = 1'b1;
            end
            default: begin
`ifdef BIP_ILLEGAL_HALT_EN
              w_state_nxt  = S_HALT;
              w_halted_nxt = 1'b1;
              w_pc_nxt     = r_pc;
`else
              w_state_nxt  = S_RUN;
`endif
            end
          endcase
        end
      end
      S_HALT: begin
        w_halted_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  assign Prog_Addr = r_pc;
  assign Operand   = r_operand;
  assign Sel_A     = r_sel_a;
  assign Sel_B     = r_sel_b;
  assign Op        = r_op;
  assign Wr_Acc    = r_wr_acc;
  assign Wr_Ram    = r_wr_ram;
  assign Halted    = r_halted;

endmodule

// File: doc/bip_fetch_decode.md
# bip_fetch_decode

Instruction fetch and decode unit for the 16-bit accumulator CPU. It sits directly upstream of the program memory: it drives the memory's address bus from its program counter and consumes the combinational instruction word returned. Each word is split into a 5-bit opcode and an 11-bit operand, and decoded into registered control strobes for the datapath (accumulator, ALU, data RAM). A halt state freezes execution until reset.

## Interface
- addr_bus, 11, program counter / program address width
- data_size, 16, instruction word width; opcode = bits [data_size-1 : data_size-5], operand = bits [addr_bus-1 : 0]
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- Enable  input  1  advance enable; low = stall
- Prog_Data  input  data_size  instruction word from program memory, combinational on Prog_Addr
- Prog_Addr  output  addr_bus  program counter
- Operand  output  addr_bus  registered operand of the decoded instruction
- Sel_A  output  2  accumulator source: 0 RAM data, 1 immediate (Operand), 2 ALU result
- Sel_B  output  1  ALU B source: 0 RAM data, 1 immediate
- Op  output  1  ALU operation: 0 add, 1 subtract
- Wr_Acc  output  1  accumulator write strobe
- Wr_Ram  output  1  data RAM write strobe (address = Operand, data = accumulator)
- Halted  output  1  CPU halted

## Operation
- Reset: Prog_Addr=0, Operand=0, Sel_A=0, Sel_B=0, Op=0, Wr_Acc=0, Wr_Ram=0, Halted=0, state RUN.
- States: RUN, HALT. Reset from any state, at any time, returns to RUN with reset values.
- RUN, Enable=1, each clock: decode Prog_Data; register controls and Operand; Prog_Addr <= Prog_Addr+1 (wraps 2^addr_bus-1 -> 0).
- RUN, Enable=0: Prog_Addr, Operand, Sel_A, Sel_B, Op hold; Wr_Acc and Wr_Ram forced 0 (no repeated write on stall).
- Decode (unlisted outputs = 0):
  - HLT 00000: all strobes 0; state -> HALT; Prog_Addr not incremented.
  - STO 00001: Wr_Ram=1.
  - LD 00010: Sel_A=0, Wr_Acc=1.
  - LDI 00011: Sel_A=1, Wr_Acc=1.
  - ADD 00100: Sel_A=2, Sel_B=0, Op=0, Wr_Acc=1.
  - ADDI 00101: Sel_A=2, Sel_B=1, Op=0, Wr_Acc=1.
  - SUB 00110: Sel_A=2, Sel_B=0, Op=1, Wr_Acc=1.
  - SUBI 00111: Sel_A=2, Sel_B=1, Op=1, Wr_Acc=1.
  - 01000–11111: see Configuration.
- HALT: Halted=1; Prog_Addr holds the HLT address; all strobes 0; Enable ignored; exit only via Reset.
- Operand = Prog_Data[addr_bus-1:0], zero-extended by datapath as needed; bits between operand and opcode ignored.

## Timing
- Fetch combinational: instruction at Prog_Addr=k is sampled at the edge ending cycle n.
- Decode latency 1 cycle: controls/Operand for instruction k are valid during cycle n+1, while instruction k+1 is fetched.
- First cycle after reset release: all strobes 0 (no instruction decoded yet).
- HLT sampled at edge ending cycle n: Halted=1 and strobes 0 from cycle n+1; previous instruction's strobes were in cycle n.
- Enable low in cycle n: edge ending cycle n makes no state change except strobe clearing; strobes 0 in cycle n+1.
- Asynchronous Reset: outputs take reset values immediately on assertion, independent of Clk.

## Configuration
- BIP_ILLEGAL_HALT_EN defined: opcodes 01000–11111 decode as HLT (enter HALT, Halted=1, PC holds).
- Not defined: those opcodes decode as NOP: all strobes 0, Operand still registered, PC increments, state stays RUN.

## Test plan
- Reset then Enable=1 with program 0x1810, 0x0801, 0x1001, 0x28FF, 0x0802, 0x1010, 0x0000 -> cycles 1..6: LDI(Sel_A=1,Wr_Acc,Operand=16), STO(Wr_Ram,Operand=1), LD(Sel_A=0,Wr_Acc,Operand=1), ADDI(Sel_A=2,Sel_B=1,Op=0,Operand=255), STO(Operand=2), LD(Operand=16); cycle 7 Halted=1, Prog_Addr=6 forever.
- SUB 0x3005 then SUBI 0x3805 -> Sel_A=2, Op=1, Wr_Acc=1, Sel_B=0 then 1, Operand=5.
- Enable low for 3 cycles mid-program at Prog_Addr=3 -> Prog_Addr stays 3, Wr_Acc/Wr_Ram 0 during stall; execution resumes with ADDI, no duplicated write strobe.
- Preload 0x1800 at PC 2047 -> Prog_Addr wraps to 0, LDI decoded with Operand=0.
- Word 0x4000 at PC 0, both macro settings -> defined: Halted=1, Prog_Addr=0; undefined: strobes 0, Prog_Addr=1, Halted=0.
- Assert Reset asynchronously during HALT and mid-run between edges -> outputs return to reset values immediately; execution restarts at address 0.
